// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one SRAM-like memory port between the I-cache miss path
//             and the D-cache/uncached path.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_dok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_dok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic [31:0] mem_rdata,
    input  logic        mem_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);
    localparam logic             c_own_inst   = 1'b0;
    localparam logic             c_own_data   = 1'b1;

    state_t             r_state,      w_state_nxt;
    logic               r_owner,      w_owner_nxt;
    logic [CNT_W-1:0]   r_starve_cnt, w_starve_nxt;
    logic [31:0]        r_addr,       w_addr_nxt;
    logic               r_wr,         w_wr_nxt;
    logic [1:0]         r_size,       w_size_nxt;
    logic [31:0]        r_wdata,      w_wdata_nxt;

    logic               w_grant_data;

    // Data wins unless instruction has been passed over STARVE_MAX times in a row.
    assign w_grant_data = data_req & (~inst_req | (r_starve_cnt < c_starve_max));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_owner      <= c_own_inst;
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_wr         <= 1'b0;
            r_size       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_addr       <= w_addr_nxt;
            r_wr         <= w_wr_nxt;
            r_size       <= w_size_nxt;
            r_wdata      <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_starve_nxt = r_starve_cnt;
        w_addr_nxt   = r_addr;
        w_wr_nxt     = r_wr;
        w_size_nxt   = r_size;
        w_wdata_nxt  = r_wdata;
        mem_req      = 1'b0;
        inst_dok     = 1'b0;
        data_dok     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_grant_data) begin
                    w_owner_nxt = c_own_data;
                    w_addr_nxt  = data_addr;
                    w_wr_nxt    = data_wr;
                    w_size_nxt  = data_size;
                    w_wdata_nxt = data_wdata;
                    if (!inst_req) begin
                        w_starve_nxt = '0;
                    end else if (r_starve_cnt < c_starve_max) begin
                        w_starve_nxt = r_starve_cnt + CNT_W'(1);
                    end
                    w_state_nxt = ADDR;
                end else if (inst_req) begin
                    w_owner_nxt  = c_own_inst;
                    w_addr_nxt   = inst_addr;
                    w_wr_nxt     = 1'b0;
                    w_size_nxt   = 2'd2;
                    w_wdata_nxt  = '0;
                    w_starve_nxt = '0;
                    w_state_nxt  = ADDR;
                end
            end
            ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    inst_dok    = (r_owner == c_own_inst);
                    data_dok    = (r_owner == c_own_data);
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem_wr     = r_wr;
    assign mem_size   = r_size;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Scoreboard bench for mem_port_arbiter with a stallable memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_dok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_dok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic [31:0] mem_rdata;
    logic        mem_data_ok;

    mem_port_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_dok(inst_dok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_dok(data_dok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_rdata(mem_rdata),
        .mem_data_ok(mem_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   dok_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   addr_wait = 0;
    int   data_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_content(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C1D_A000;
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // Memory model: addr_ok after addr_wait cycles of mem_req, data_ok data_wait cycles into DATA.
    initial begin : memory_model
        int          phase;
        int          cnt;
        logic [31:0] lat_addr;
        phase = 0; cnt = 0; lat_addr = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            mem_rdata   = 32'hDEAD_BEEF;
            if (!resetn) begin
                phase = 0; cnt = 0;
            end else if (phase == 0) begin
                if (mem_req) begin
                    if (cnt >= addr_wait) begin
                        mem_addr_ok = 1'b1; lat_addr = mem_addr; phase = 1; cnt = 0;
                    end else cnt++;
                end
            end else begin
                if (cnt >= data_wait) begin
                    mem_data_ok = 1'b1; mem_rdata = mem_content(lat_addr); phase = 0; cnt = 0;
                end else cnt++;
            end
        end
    end

    // Scoreboard: compare each address handshake and each dok against the queue head.
    initial begin : monitor
        logic        prev_req, prev_hs;
        logic [31:0] p_addr, p_wdata;
        logic        p_wr;
        logic [1:0]  p_size;
        prev_req = 0; prev_hs = 0; p_addr = '0; p_wdata = '0; p_wr = 0; p_size = '0;
        forever begin
            @(negedge clk); #2;
            if (!resetn) begin
                prev_req = 0; prev_hs = 0;
            end else begin
                if (prev_req && !prev_hs) begin
                    n_checks++;
                    if (mem_req !== 1'b1 || mem_addr !== p_addr || mem_wr !== p_wr ||
                        mem_size !== p_size || mem_wdata !== p_wdata) begin
                        n_fail++;
                        $display("FAIL addr_stall_stable: req=%b addr=%h wr=%b size=%0d wdata=%h, required req=1 addr=%h wr=%b size=%0d wdata=%h",
                                 mem_req, mem_addr, mem_wr, mem_size, mem_wdata, p_addr, p_wr, p_size, p_wdata);
                    end
                end
                if (prev_hs) begin
                    n_checks++;
                    if (mem_req !== 1'b0) begin
                        n_fail++;
                        $display("FAIL req_in_data: mem_req=%b, required 0", mem_req);
                    end
                end
                if (mem_req && !prev_req) rise_q.push_back(cyc);
                if (mem_req && mem_addr_ok) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_grant: addr=%h, required no transaction", mem_addr);
                    end else if (mem_addr !== exp_q[0].addr || mem_wr !== exp_q[0].wr ||
                                 mem_size !== exp_q[0].size ||
                                 (exp_q[0].wr && mem_wdata !== exp_q[0].wdata)) begin
                        n_fail++;
                        $display("FAIL grant_fields: addr=%h wr=%b size=%0d wdata=%h, required addr=%h wr=%b size=%0d wdata=%h",
                                 mem_addr, mem_wr, mem_size, mem_wdata,
                                 exp_q[0].addr, exp_q[0].wr, exp_q[0].size, exp_q[0].wdata);
                    end
                end
                if (inst_dok || data_dok) begin
                    n_checks++;
                    dok_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_dok: inst_dok=%b data_dok=%b, required none", inst_dok, data_dok);
                    end else begin
                        if (inst_dok === exp_q[0].is_data || data_dok !== exp_q[0].is_data ||
                            (exp_q[0].is_data ? data_rdata : inst_rdata) !== exp_q[0].rdata) begin
                            n_fail++;
                            $display("FAIL dok_owner_data: inst_dok=%b data_dok=%b rdata=%h, required data_side=%b rdata=%h",
                                     inst_dok, data_dok, exp_q[0].is_data ? data_rdata : inst_rdata,
                                     exp_q[0].is_data, exp_q[0].rdata);
                        end
                        void'(exp_q.pop_front());
                    end
                end
                prev_req = mem_req;
                prev_hs  = mem_req & mem_addr_ok;
                p_addr = mem_addr; p_wr = mem_wr; p_size = mem_size; p_wdata = mem_wdata;
            end
        end
    end

    task automatic run_inst(input int n, input logic [31:0] base);
        bit seen;
        for (int i = 0; i < n; i++) begin
            inst_addr = base + 32'(4 * i);
            inst_req  = 1'b1;
            seen = 0;
            for (int k = 0; k < 300 && !seen; k++) begin
                @(negedge clk); #2;
                if (inst_dok) seen = 1;
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL inst_timeout: inst_dok=0, required 1 within 300 cycles");
            end
            @(posedge clk); #1;
        end
        inst_req = 1'b0;
    endtask

    task automatic run_data(input int n, input logic [31:0] base, input logic wr,
                            input logic [1:0] size, input logic [31:0] wdata);
        bit seen;
        for (int i = 0; i < n; i++) begin
            data_addr  = base + 32'(4 * i);
            data_wr    = wr;
            data_size  = size;
            data_wdata = wdata + 32'(i);
            data_req   = 1'b1;
            seen = 0;
            for (int k = 0; k < 300 && !seen; k++) begin
                @(negedge clk); #2;
                if (data_dok) seen = 1;
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL data_timeout: data_dok=0, required 1 within 300 cycles");
            end
            @(posedge clk); #1;
        end
        data_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #2;
        n_checks++;
        if (mem_req !== 1'b0 || inst_dok !== 1'b0 || data_dok !== 1'b0 || mem_addr !== 32'h0 ||
            mem_wr !== 1'b0 || mem_size !== 2'd0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b idok=%b ddok=%b addr=%h wr=%b size=%0d wdata=%h, required all 0",
                     mem_req, inst_dok, data_dok, mem_addr, mem_wr, mem_size, mem_wdata);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_inst_read();
        int c0;
        exp_t e;
        addr_wait = 0; data_wait = 0;
        rise_q.delete(); dok_q.delete();
        e = '{is_data: 0, addr: 32'hBFC0_0000, wr: 0, size: 2'd2, wdata: 32'h0, rdata: 32'h3C1D_A000};
        exp_q.push_back(e);
        c0 = cyc;
        run_inst(1, 32'hBFC0_0000);
        n_checks++;
        if (dok_q.size() != 1 || dok_q[0] - c0 != 2) begin
            n_fail++;
            $display("FAIL inst_latency: doks=%0d latency=%0d, required 1 dok at 2",
                     dok_q.size(), dok_q.size() ? dok_q[0] - c0 : -1);
        end
    endtask

    task automatic test_data_write();
        exp_t e;
        addr_wait = 1; data_wait = 2;
        rise_q.delete(); dok_q.delete();
        e = '{is_data: 1, addr: 32'h8000_1003, wr: 1, size: 2'd0, wdata: 32'h0000_00AA,
              rdata: mem_content(32'h8000_1003)};
        exp_q.push_back(e);
        run_data(1, 32'h8000_1003, 1'b1, 2'd0, 32'h0000_00AA);
        n_checks++;
        if (dok_q.size() != 1) begin
            n_fail++;
            $display("FAIL data_write_doks: doks=%0d, required 1", dok_q.size());
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        addr_wait = 0; data_wait = 0;
        rise_q.delete(); dok_q.delete();
        e = '{is_data: 1, addr: 32'h8000_2000, wr: 0, size: 2'd2, wdata: 32'h0, rdata: mem_content(32'h8000_2000)};
        exp_q.push_back(e);
        e = '{is_data: 0, addr: 32'hBFC0_0100, wr: 0, size: 2'd2, wdata: 32'h0, rdata: mem_content(32'hBFC0_0100)};
        exp_q.push_back(e);
        fork
            run_data(1, 32'h8000_2000, 1'b0, 2'd2, 32'h0);
            run_inst(1, 32'hBFC0_0100);
        join
        n_checks++;
        if (dok_q.size() != 2 || rise_q.size() != 2 || rise_q[1] - dok_q[0] != 2) begin
            n_fail++;
            $display("FAIL simul_order: doks=%0d grants=%0d gap=%0d, required 2 2 2",
                     dok_q.size(), rise_q.size(),
                     (dok_q.size() > 0 && rise_q.size() > 1) ? rise_q[1] - dok_q[0] : -1);
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        addr_wait = 0; data_wait = 0;
        rise_q.delete(); dok_q.delete();
        // Four data wins, forced inst, counter cleared so two more data, then inst again.
        for (int i = 0; i < 8; i++) begin
            int d;
            bit is_d;
            is_d = !(i == 4 || i == 7);
            d = (i < 4) ? i : i - 1;
            if (is_d)
                e = '{is_data: 1, addr: 32'h8000_0100 + 32'(4 * d), wr: 0, size: 2'd2, wdata: 32'h0,
                      rdata: mem_content(32'h8000_0100 + 32'(4 * d))};
            else
                e = '{is_data: 0, addr: 32'hBFC0_0200 + 32'((i == 7) ? 4 : 0), wr: 0, size: 2'd2, wdata: 32'h0,
                      rdata: mem_content(32'hBFC0_0200 + 32'((i == 7) ? 4 : 0))};
            exp_q.push_back(e);
        end
        fork
            run_data(6, 32'h8000_0100, 1'b0, 2'd2, 32'h0);
            run_inst(2, 32'hBFC0_0200);
        join
        n_checks++;
        if (dok_q.size() != 8) begin
            n_fail++;
            $display("FAIL starve_count: doks=%0d, required 8", dok_q.size());
        end
    endtask

    task automatic test_stalls();
        exp_t e;
        addr_wait = 5; data_wait = 7;
        rise_q.delete(); dok_q.delete();
        e = '{is_data: 1, addr: 32'h8000_3004, wr: 1, size: 2'd1, wdata: 32'h0000_BEEF,
              rdata: mem_content(32'h8000_3004)};
        exp_q.push_back(e);
        run_data(1, 32'h8000_3004, 1'b1, 2'd1, 32'h0000_BEEF);
        n_checks++;
        if (dok_q.size() != 1 || rise_q.size() != 1 || dok_q[0] - rise_q[0] != 13) begin
            n_fail++;
            $display("FAIL stall_timing: doks=%0d grants=%0d req_to_dok=%0d, required 1 1 13",
                     dok_q.size(), rise_q.size(),
                     (dok_q.size() > 0 && rise_q.size() > 0) ? dok_q[0] - rise_q[0] : -1);
        end
    endtask

    task automatic test_reset_in_data();
        exp_t e;
        bit hs;
        addr_wait = 0; data_wait = 20;
        rise_q.delete(); dok_q.delete();
        e = '{is_data: 0, addr: 32'hBFC0_0040, wr: 0, size: 2'd2, wdata: 32'h0, rdata: 32'h0};
        exp_q.push_back(e);
        inst_addr = 32'hBFC0_0040;
        inst_req  = 1'b1;
        hs = 0;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk); #2;
            if (mem_req && mem_addr_ok) hs = 1;
        end
        n_checks++;
        if (!hs) begin
            n_fail++;
            $display("FAIL abort_handshake: handshake=0, required 1");
        end
        @(negedge clk); #3;
        resetn   = 1'b0;
        inst_req = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || inst_dok !== 1'b0 || data_dok !== 1'b0 || mem_addr !== 32'h0 || mem_size !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_state: req=%b idok=%b ddok=%b addr=%h size=%0d, required 0 0 0 0 0",
                     mem_req, inst_dok, data_dok, mem_addr, mem_size);
        end
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        data_wait = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dok_q.size() != 0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_dok: doks=%0d mem_req=%b, required 0 0", dok_q.size(), mem_req);
        end
        e = '{is_data: 0, addr: 32'hBFC0_0080, wr: 0, size: 2'd2, wdata: 32'h0, rdata: mem_content(32'hBFC0_0080)};
        exp_q.push_back(e);
        run_inst(1, 32'hBFC0_0080);
        n_checks++;
        if (dok_q.size() != 1) begin
            n_fail++;
            $display("FAIL after_reset_txn: doks=%0d, required 1", dok_q.size());
        end
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_inst_read();
        test_data_write();
        test_simultaneous();
        test_starvation();
        test_stalls();
        test_reset_in_data();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
